// File: rtl/wb_int_ctrl_pkg.sv
// Shared definitions for the Wishbone interrupt controller: register map,
// the value returned by an empty claim, and the bus FSM state encoding.
package wb_int_pkg;

    localparam int N_SRC_DEF = 6;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    localparam logic [31:0] CAUSE_NONE = 32'hFFFF_FFFF;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_int_ctrl_src_sync.sv
// One interrupt source: two-flop synchroniser into clk plus a third flop
// so a rising edge of the synchronised level can be reported as a pulse.
module int_src_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic src_async,
    output logic level,
    output logic rise
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = src_async;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/wb_int_ctrl.sv
// Wishbone-slave interrupt controller: latches synchronised sources as pending,
// masks and prioritises them (index 0 wins), and drives CPU INT / Cause.
module wb_int_ctrl
    import wb_int_pkg::*;
#(
    parameter int                N_SRC    = N_SRC_DEF,
    parameter logic [N_SRC-1:0]  EDGE_RST = {N_SRC{1'b1}}
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             STB,
    input  logic             WE,
    input  logic [1:0]       ADDR,
    input  logic [31:0]      DAT_I,
    output logic [31:0]      DAT_O,
    output logic             ACK,
    output logic             cpu_int,
    output logic [31:0]      cpu_cause,
    output wb_state_e        dbg_wb_state
);

    localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] src_lvl;
    logic [N_SRC-1:0] src_rise;

    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] edge_q, edge_d;
    logic             insvc_valid_q, insvc_valid_d;
    logic [ID_W-1:0]  insvc_id_q, insvc_id_d;
    logic             cpu_int_q, cpu_int_d;
    logic [31:0]      cpu_cause_q, cpu_cause_d;
    logic [31:0]      dat_o_q, dat_o_d;
    wb_state_e        state_q, state_d;

    logic [N_SRC-1:0] eligible;
    logic             any_elig;
    logic [ID_W-1:0]  winner;
    logic [N_SRC-1:0] winner_oh;
    logic [N_SRC-1:0] clr;
    logic             access;
    logic             unused_dat;

    assign unused_dat = ^DAT_I[31:8];

    for (genvar g = 0; g < N_SRC; g++) begin : g_sync
        int_src_sync u_sync (
            .clk       (clk),
            .rst_n     (RSTN),
            .src_async (src_irq[g]),
            .level     (src_lvl[g]),
            .rise      (src_rise[g])
        );
    end

    // Scan from the top down so the lowest eligible index is the one left standing.
    always_comb begin
        eligible  = pending_q & mask_q;
        any_elig  = |eligible;
        winner    = '0;
        winner_oh = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner       = ID_W'(i);
                winner_oh    = '0;
                winner_oh[i] = 1'b1;
            end
        end
    end

    // Bus handshake: in WB_IDLE a cycle with STB=1 performs exactly one access
    // (register update and side effects happen on that edge) and moves to WB_ACK,
    // where ACK and the registered DAT_O are presented for one cycle; the FSM
    // always returns to WB_IDLE next, so a held STB only re-executes after ACK drops.
    always_comb begin
        state_d       = state_q;
        dat_o_d       = '0;
        clr           = '0;
        mask_d        = mask_q;
        edge_d        = edge_q;
        insvc_valid_d = insvc_valid_q;
        insvc_id_d    = insvc_id_q;
        access        = (state_q == WB_IDLE) && STB;

        case (state_q)
            WB_IDLE: if (STB) state_d = WB_ACK;
            WB_ACK:  state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase

        if (access) begin
            if (WE) begin
                case (ADDR)
                    REG_PENDING: clr    = DAT_I[N_SRC-1:0];
                    REG_MASK:    mask_d = DAT_I[N_SRC-1:0];
                    REG_EDGE:    edge_d = DAT_I[N_SRC-1:0];
                    default: begin
                        if (insvc_valid_q && (DAT_I[7:0] == 8'(insvc_id_q)))
                            insvc_valid_d = 1'b0;
                    end
                endcase
            end else begin
                case (ADDR)
                    REG_PENDING: dat_o_d = 32'(pending_q);
                    REG_MASK:    dat_o_d = 32'(mask_q);
                    REG_EDGE:    dat_o_d = 32'(edge_q);
                    default: begin
                        if (cpu_int_q && any_elig) begin
                            dat_o_d       = 32'(winner);
                            clr           = winner_oh;
                            insvc_valid_d = 1'b1;
                            insvc_id_d    = winner;
                        end else begin
                            dat_o_d = CAUSE_NONE;
                        end
                    end
                endcase
            end
        end

        // Edge bits: a new rise beats a same-cycle clear. Level bits track the input.
        pending_d = (edge_q & ((pending_q & ~clr) | src_rise)) | (~edge_q & src_lvl);

        cpu_int_d   = ~insvc_valid_q & any_elig;
        cpu_cause_d = cpu_int_d ? 32'(winner) : cpu_cause_q;
    end

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= WB_IDLE;
            dat_o_q       <= '0;
            pending_q     <= '0;
            mask_q        <= '0;
            edge_q        <= EDGE_RST;
            insvc_valid_q <= 1'b0;
            insvc_id_q    <= '0;
            cpu_int_q     <= 1'b0;
            cpu_cause_q   <= '0;
        end else begin
            state_q       <= state_d;
            dat_o_q       <= dat_o_d;
            pending_q     <= pending_d;
            mask_q        <= mask_d;
            edge_q        <= edge_d;
            insvc_valid_q <= insvc_valid_d;
            insvc_id_q    <= insvc_id_d;
            cpu_int_q     <= cpu_int_d;
            cpu_cause_q   <= cpu_cause_d;
        end
    end

    assign DAT_O        = dat_o_q;
    assign ACK          = (state_q == WB_ACK);
    assign cpu_int      = cpu_int_q;
    assign cpu_cause    = cpu_cause_q;
    assign dbg_wb_state = state_q;

endmodule

// File: tb/tb_wb_int_ctrl.sv
// Directed bench for wb_int_ctrl: bus accesses driven on the falling edge,
// every output sampled on the falling edge against hand-computed values.
module tb_wb_int_ctrl;
    import wb_int_pkg::*;

    logic        clk = 1'b0;
    logic        RSTN = 1'b0;
    logic [5:0]  src_irq = '0;
    logic        STB = 1'b0;
    logic        WE = 1'b0;
    logic [1:0]  ADDR = '0;
    logic [31:0] DAT_I = '0;
    logic [31:0] DAT_O;
    logic        ACK;
    logic        cpu_int;
    logic [31:0] cpu_cause;
    wb_state_e   dbg_wb_state;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd;
    logic [3:0]  ack_pat;

    wb_int_ctrl dut (
        .clk          (clk),
        .RSTN         (RSTN),
        .src_irq      (src_irq),
        .STB          (STB),
        .WE           (WE),
        .ADDR         (ADDR),
        .DAT_I        (DAT_I),
        .DAT_O        (DAT_O),
        .ACK          (ACK),
        .cpu_int      (cpu_int),
        .cpu_cause    (cpu_cause),
        .dbg_wb_state (dbg_wb_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [1:0] a, input logic we, input logic [31:0] wd,
                       output logic [31:0] rd_o);
        int n;
        ADDR  = a;
        WE    = we;
        DAT_I = wd;
        STB   = 1'b1;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ACK && n < 8);
        chk("bus_ack", {31'b0, ACK}, 32'd1);
        rd_o  = DAT_O;
        STB   = 1'b0;
        WE    = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(a, 1'b1, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus(a, 1'b0, 32'd0, v);
        chk(tag, v, exp);
    endtask

    initial begin
        // reset values
        tick(3);
        chk("rst_ack", {31'b0, ACK}, 32'd0);
        chk("rst_dat_o", DAT_O, 32'd0);
        chk("rst_int", {31'b0, cpu_int}, 32'd0);
        chk("rst_cause", cpu_cause, 32'd0);
        chk("rst_state", 32'(dbg_wb_state), 32'(WB_IDLE));
        RSTN = 1'b1;
        tick(2);
        rd_chk("rst_edge", REG_EDGE, 32'h3F);
        rd_chk("rst_mask", REG_MASK, 32'h0);

        // 1: edge source 5, latency and claim/complete
        wr(REG_MASK, 32'h3F);
        src_irq[5] = 1'b1;
        tick(2);
        src_irq[5] = 1'b0;
        tick(1);
        chk("t1_int_early", {31'b0, cpu_int}, 32'd0);
        tick(1);
        chk("t1_int", {31'b0, cpu_int}, 32'd1);
        chk("t1_cause", cpu_cause, 32'd5);
        rd_chk("t1_pending", REG_PENDING, 32'h20);
        rd_chk("t1_claim", REG_CLAIM, 32'd5);
        wr(REG_CLAIM, 32'd5);
        chk("t1_int_done", {31'b0, cpu_int}, 32'd0);
        rd_chk("t1_pending_clr", REG_PENDING, 32'h0);

        // 2: two sources together, priority, wrong-id completion ignored
        src_irq = 6'b01_0010;
        tick(1);
        src_irq = '0;
        tick(4);
        chk("t2_int", {31'b0, cpu_int}, 32'd1);
        chk("t2_cause", cpu_cause, 32'd1);
        rd_chk("t2_claim", REG_CLAIM, 32'd1);
        chk("t2_int_insvc", {31'b0, cpu_int}, 32'd0);
        chk("t2_cause_hold", cpu_cause, 32'd1);
        wr(REG_CLAIM, 32'd3);
        chk("t2_wrong_id", {31'b0, cpu_int}, 32'd0);
        wr(REG_CLAIM, 32'd1);
        chk("t2_int_next", {31'b0, cpu_int}, 32'd1);
        chk("t2_cause_next", cpu_cause, 32'd4);
        rd_chk("t2_claim4", REG_CLAIM, 32'd4);
        wr(REG_CLAIM, 32'd4);
        chk("t2_int_done", {31'b0, cpu_int}, 32'd0);
        rd_chk("t2_pending", REG_PENDING, 32'h0);

        // 3: masked pending, empty claim, unmask, W1C
        wr(REG_MASK, 32'h0);
        src_irq[2] = 1'b1;
        tick(1);
        src_irq[2] = 1'b0;
        tick(4);
        rd_chk("t3_pending", REG_PENDING, 32'h04);
        chk("t3_int_masked", {31'b0, cpu_int}, 32'd0);
        rd_chk("t3_claim_none", REG_CLAIM, CAUSE_NONE);
        chk("t3_int_still0", {31'b0, cpu_int}, 32'd0);
        wr(REG_MASK, 32'h04);
        chk("t3_int_unmask", {31'b0, cpu_int}, 32'd1);
        chk("t3_cause", cpu_cause, 32'd2);
        rd_chk("t3_mask", REG_MASK, 32'h04);
        wr(REG_PENDING, 32'h04);
        chk("t3_int_w1c", {31'b0, cpu_int}, 32'd0);
        rd_chk("t3_pending_clr", REG_PENDING, 32'h0);
        wr(REG_MASK, 32'h3F);

        // 4: level source ignores W1C and claim; clears 3 clk after drop
        wr(REG_EDGE, 32'h0);
        src_irq[3] = 1'b1;
        tick(4);
        chk("t4_int", {31'b0, cpu_int}, 32'd1);
        chk("t4_cause", cpu_cause, 32'd3);
        rd_chk("t4_pending", REG_PENDING, 32'h08);
        wr(REG_PENDING, 32'h08);
        rd_chk("t4_w1c_noeff", REG_PENDING, 32'h08);
        rd_chk("t4_claim", REG_CLAIM, 32'd3);
        rd_chk("t4_claim_noeff", REG_PENDING, 32'h08);
        wr(REG_CLAIM, 32'd3);
        src_irq[3] = 1'b0;
        tick(2);
        rd_chk("t4_pending_hold", REG_PENDING, 32'h08);
        rd_chk("t4_pending_drop", REG_PENDING, 32'h0);
        chk("t4_int_drop", {31'b0, cpu_int}, 32'd0);
        wr(REG_EDGE, 32'h3F);
        rd_chk("t4_edge", REG_EDGE, 32'h3F);

        // 5: W1C on the same edge as a new rise of that source
        src_irq[0] = 1'b1;
        tick(1);
        src_irq[0] = 1'b0;
        tick(4);
        rd_chk("t5_pending_pre", REG_PENDING, 32'h01);
        src_irq[0] = 1'b1;
        tick(2);
        wr(REG_PENDING, 32'h01);
        src_irq[0] = 1'b0;
        rd_chk("t5_set_wins", REG_PENDING, 32'h01);
        chk("t5_int", {31'b0, cpu_int}, 32'd1);
        chk("t5_cause", cpu_cause, 32'd0);
        wr(REG_PENDING, 32'h01);
        rd_chk("t5_pending_clr", REG_PENDING, 32'h0);
        chk("t5_int_clr", {31'b0, cpu_int}, 32'd0);

        // 6a: STB held four cycles on a MASK read
        ack_pat = 4'b0101;
        ADDR = REG_MASK;
        WE   = 1'b0;
        STB  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk($sformatf("t6_ack_%0d", k), {31'b0, ACK}, {31'b0, ack_pat[k]});
            if (k == 0) chk("t6_dat", DAT_O, 32'h3F);
        end
        STB = 1'b0;
        tick(1);

        // 6b: reset asserted while a claim ACK is on the bus
        src_irq[5] = 1'b1;
        tick(1);
        src_irq[5] = 1'b0;
        tick(4);
        chk("t6_int", {31'b0, cpu_int}, 32'd1);
        ADDR = REG_CLAIM;
        WE   = 1'b0;
        STB  = 1'b1;
        tick(1);
        chk("t6_claim_ack", {31'b0, ACK}, 32'd1);
        chk("t6_claim_dat", DAT_O, 32'd5);
        RSTN = 1'b0;
        #1;
        chk("t6_rst_ack", {31'b0, ACK}, 32'd0);
        chk("t6_rst_dat", DAT_O, 32'd0);
        chk("t6_rst_int", {31'b0, cpu_int}, 32'd0);
        chk("t6_rst_cause", cpu_cause, 32'd0);
        STB = 1'b0;
        tick(1);
        RSTN = 1'b1;
        tick(2);
        rd_chk("t6_pending", REG_PENDING, 32'h0);
        rd_chk("t6_mask", REG_MASK, 32'h0);
        rd_chk("t6_edge", REG_EDGE, 32'h3F);
        chk("t6_int_after", {31'b0, cpu_int}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
